redmule_mx_dec_arbiter: RTL

REDMULE_MX_DEC_ARBITER -- requirements
Module: redmule_mx_dec_arbiter

---
 rtl/redmule_mx_pkg.sv | 20 ++
 rtl/redmule_mx_dec_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/redmule_mx_pkg.sv
// Shared definitions for the MX decoder arbiter: FSM state encoding,
// MX element width and the beat-count helper.
package redmule_mx_pkg;

  typedef enum logic [1:0] {
    MX_IDLE  = 2'd0,
    MX_ISSUE = 2'd1,
    MX_DRAIN = 2'd2
  } mx_arb_state_e;

  // Width of one FP8 E4M3 element inside an MX value block.
  localparam int unsigned MX_ELEM_W = 8;

  // Decoder output beats produced for one value block.
  function automatic int unsigned mx_num_groups(input int unsigned data_w,
                                                input int unsigned num_lanes);
    return data_w / MX_ELEM_W / num_lanes;
  endfunction

endpackage

// File: rtl/redmule_mx_dec_arbiter.sv
// Two-requester arbiter sharing one MX decoder. A block (value + shared
// exponent) is granted, issued to the decoder, and the decoder's FP16
// beats are steered back to the owner before the next grant.
//
// state    | meaning
// ---------+---------------------------------------------------------
// MX_IDLE  | no owner; all handshakes closed, pick next eligible rq
// MX_ISSUE | owner's value/exponent offered to decoder, wait joint hs
// MX_DRAIN | decoder FP16 beats routed to owner until last group
module redmule_mx_dec_arbiter
  import redmule_mx_pkg::*;
#(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BITW      = 16,
  parameter int unsigned NUM_LANES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      rq0_val_valid_i,
  output logic                      rq0_val_ready_o,
  input  logic [DATA_W-1:0]         rq0_val_data_i,
  input  logic                      rq0_exp_valid_i,
  output logic                      rq0_exp_ready_o,
  input  logic [7:0]                rq0_exp_data_i,

  input  logic                      rq1_val_valid_i,
  output logic                      rq1_val_ready_o,
  input  logic [DATA_W-1:0]         rq1_val_data_i,
  input  logic                      rq1_exp_valid_i,
  output logic                      rq1_exp_ready_o,
  input  logic [7:0]                rq1_exp_data_i,

  output logic                      dec_val_valid_o,
  input  logic                      dec_val_ready_i,
  output logic [DATA_W-1:0]         dec_val_data_o,
  output logic                      dec_exp_valid_o,
  input  logic                      dec_exp_ready_i,
  output logic [7:0]                dec_exp_data_o,

  input  logic                      dec_fp16_valid_i,
  output logic                      dec_fp16_ready_o,
  input  logic [NUM_LANES*BITW-1:0] dec_fp16_data_i,

  output logic                      out0_valid_o,
  input  logic                      out0_ready_i,
  output logic [NUM_LANES*BITW-1:0] out0_data_o,
  output logic                      out1_valid_o,
  input  logic                      out1_ready_i,
  output logic [NUM_LANES*BITW-1:0] out1_data_o,

  output logic                      busy_o,
  output logic                      owner_o,
  output logic                      err_o
);

  localparam int unsigned NUM_GROUPS = mx_num_groups(DATA_W, NUM_LANES);
  localparam int unsigned CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_GROUPS - 1);

  mx_arb_state_e    r_state;
  logic             r_owner;
  logic             r_last;
  logic             r_err;
  logic [CNT_W-1:0] r_beat_cnt;

  logic w_elig0;
  logic w_elig1;
  logic w_pick;
  logic w_in_issue;
  logic w_in_drain;
  logic w_own_val_valid;
  logic w_own_exp_valid;
  logic w_own_both;
  logic w_val_rdy;
  logic w_exp_rdy;
  logic w_issue_hs;
  logic w_own_out_ready;
  logic w_beat;
  logic w_drain0;
  logic w_drain1;

  assign w_elig0    = rq0_val_valid_i & rq0_exp_valid_i;
  assign w_elig1    = rq1_val_valid_i & rq1_exp_valid_i;
  assign w_in_issue = (r_state == MX_ISSUE);
  assign w_in_drain = (r_state == MX_DRAIN);

  // Grant choice: single eligible requester wins, a tie goes to the one
  // that was not served last.
  always_comb begin
    w_pick = 1'b0;
    if (w_elig0 && w_elig1) begin
      w_pick = ~r_last;
    end else if (w_elig1) begin
      w_pick = 1'b1;
    end
  end

  assign w_own_val_valid = r_owner ? rq1_val_valid_i : rq0_val_valid_i;
  assign w_own_exp_valid = r_owner ? rq1_exp_valid_i : rq0_exp_valid_i;
  assign w_own_both      = w_own_val_valid & w_own_exp_valid;

  assign dec_val_valid_o = w_in_issue & w_own_val_valid;
  assign dec_exp_valid_o = w_in_issue & w_own_exp_valid;
  assign dec_val_data_o  = w_in_issue ? (r_owner ? rq1_val_data_i : rq0_val_data_i) : '0;
  assign dec_exp_data_o  = w_in_issue ? (r_owner ? rq1_exp_data_i : rq0_exp_data_i) : '0;

  // Readies require both owner valids so value and exponent leave together.
  assign w_val_rdy  = w_in_issue & dec_val_ready_i & w_own_both;
  assign w_exp_rdy  = w_in_issue & dec_exp_ready_i & w_own_both;
  assign w_issue_hs = w_val_rdy & w_exp_rdy;

  assign rq0_val_ready_o = w_val_rdy & ~r_owner;
  assign rq0_exp_ready_o = w_exp_rdy & ~r_owner;
  assign rq1_val_ready_o = w_val_rdy & r_owner;
  assign rq1_exp_ready_o = w_exp_rdy & r_owner;

  assign w_own_out_ready  = r_owner ? out1_ready_i : out0_ready_i;
  assign dec_fp16_ready_o = w_in_drain & w_own_out_ready;
  assign w_beat           = dec_fp16_valid_i & dec_fp16_ready_o;

  assign w_drain0     = w_in_drain & ~r_owner;
  assign w_drain1     = w_in_drain & r_owner;
  assign out0_valid_o = w_drain0 & dec_fp16_valid_i;
  assign out1_valid_o = w_drain1 & dec_fp16_valid_i;
  assign out0_data_o  = w_drain0 ? dec_fp16_data_i : '0;
  assign out1_data_o  = w_drain1 ? dec_fp16_data_i : '0;

  assign busy_o  = (r_state != MX_IDLE);
  assign owner_o = r_owner;
  assign err_o   = r_err;

  // Grant / issue / drain sequencing with beat counting.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= MX_IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        MX_IDLE: begin
          if (w_elig0 || w_elig1) begin
            r_owner <= w_pick;
            r_state <= MX_ISSUE;
          end
        end
        MX_ISSUE: begin
          if (w_issue_hs) begin
            r_beat_cnt <= '0;
            r_state    <= MX_DRAIN;
          end
        end
        MX_DRAIN: begin
          if (w_beat) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_last     <= r_owner;
              r_beat_cnt <= '0;
              r_state    <= MX_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= MX_IDLE;
      endcase
    end
  end

  // Decoder output outside DRAIN is a protocol violation; latch it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (dec_fp16_valid_i && !w_in_drain) begin
      r_err <= 1'b1;
    end
  end

endmodule
